// File: rtl/rom_arb_pkg.sv
// rom_arb_pkg: shared defaults and index-width helper for the ROM round-robin arbiter
package rom_arb_pkg;
  localparam int AW_DEF = 4;
  localparam int DW_DEF = 4;
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rom_rr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first set req at or after ptr wrapping modulo N
module rr_pick
  import rom_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx
);
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        gnt = '0;
        gnt[(int'(ptr) + k) % N] = 1'b1;
        idx = PW'((int'(ptr) + k) % N);
      end
    end
  end
endmodule

// File: rtl/rom_rr_arbiter.sv
// rom_rr_arbiter: round-robin sharing of one synchronous-read ROM among N requesters
module rom_rr_arbiter
  import rom_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic [N*AW-1:0] req_addr,
  output logic [N-1:0]  gnt,
  output logic [N-1:0]  rsp_valid,
  output logic [DW-1:0] rsp_data,
  output logic          busy,
  output logic          rom_en,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data
);
  localparam int PW = idx_w(N);
  logic [PW-1:0] ptr_q, ptr_d, idx;
  logic [N-1:0]  pick, gnt_q;
  rr_pick #(.N(N), .PW(PW)) u_pick (
    .req(req),
    .ptr(ptr_q),
    .gnt(pick),
    .idx(idx)
  );
  always_comb begin
    gnt      = rst_n ? pick : '0;
    rom_en   = |gnt;
    rom_addr = rom_en ? req_addr[idx*AW +: AW] : '0;
    ptr_d    = rom_en ? ((int'(idx) == N - 1) ? '0 : idx + 1'b1) : ptr_q;
  end
  assign rsp_valid = gnt_q;
  assign busy      = |gnt_q;
  assign rsp_data  = busy ? rom_data : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      gnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      gnt_q <= gnt;
    end
  end
endmodule

// File: tb/tb_rom_rr_arbiter.sv
// tb_rom_rr_arbiter: directed checks of grant order, ROM response timing and reset behaviour
module tb_rom_rr_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [15:0] req_addr = '0;
  logic [3:0]  gnt, rsp_valid, rsp_data, rom_addr;
  logic        busy, rom_en;
  logic [3:0]  rom_data;
  logic [3:0]  rom [16];
  int checks = 0;
  int errors = 0;

  rom_rr_arbiter #(.N(4), .AW(4), .DW(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy), .rom_en(rom_en),
    .rom_addr(rom_addr), .rom_data(rom_data)
  );

  always #5 clk = ~clk;

  // ROM word a is 15-a; idle cycles drive X so gating can be observed
  initial for (int i = 0; i < 16; i++) rom[i] = 4'(15 - i);
  always @(posedge clk) rom_data <= rom_en ? rom[rom_addr] : 4'bxxxx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] eg, input logic [3:0] ea,
                         input logic [3:0] ev, input logic [3:0] ed);
    chk({tag, " gnt"}, 32'(gnt), 32'(eg));
    chk({tag, " rom_en"}, 32'(rom_en), 32'(|eg));
    chk({tag, " rom_addr"}, 32'(rom_addr), 32'(ea));
    chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'(ev));
    chk({tag, " rsp_data"}, 32'(rsp_data), 32'(ed));
    chk({tag, " busy"}, 32'(busy), 32'(|ev));
  endtask

  logic [3:0] seq_g [8] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8};
  logic [3:0] seq_a [8] = '{4'h6, 4'h3, 4'hF, 4'h8, 4'h6, 4'h3, 4'hF, 4'h8};
  logic [3:0] seq_v [8] = '{4'h8, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4};
  logic [3:0] seq_d [8] = '{4'h7, 4'h9, 4'hC, 4'h0, 4'h7, 4'h9, 4'hC, 4'h0};

  initial begin
    req = 4'hF;
    req_addr = 16'h1234;
    repeat (2) @(negedge clk);
    #1 chk_out("in_reset", 4'h0, 4'h0, 4'h0, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'h0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1 chk_out("idle", 4'h0, 4'h0, 4'h0, 4'h0);
    end
    @(negedge clk);
    req = 4'b0001;
    req_addr = 16'h000A;
    #1 chk_out("single_T", 4'h1, 4'hA, 4'h0, 4'h0);
    @(negedge clk);
    req = 4'b1000;
    req_addr = 16'h8000;
    #1 chk_out("single_T1", 4'h8, 4'h8, 4'h1, 4'h5);
    @(negedge clk);
    req = 4'hF;
    req_addr = 16'h8F36;
    for (int c = 0; c < 8; c++) begin
      #1 chk_out($sformatf("all_req%0d", c), seq_g[c], seq_a[c], seq_v[c], seq_d[c]);
      @(negedge clk);
    end
    req = 4'b0100;
    #1 chk_out("rot_g2", 4'h4, 4'hF, 4'h8, 4'h7);
    @(negedge clk);
    req = 4'b0101;
    #1 chk_out("rot_wrap", 4'h1, 4'h6, 4'h4, 4'h0);
    @(negedge clk);
    #1 chk_out("rot_next", 4'h4, 4'hF, 4'h1, 4'h9);
    @(negedge clk);
    req = 4'hF;
    #1 chk_out("pre_rst", 4'h8, 4'h8, 4'h4, 4'h0);
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk_out("mid_rst", 4'h0, 4'h0, 4'h0, 4'h0);
    @(negedge clk);
    #1 chk_out("mid_rst2", 4'h0, 4'h0, 4'h0, 4'h0);
    rst_n = 1'b1;
    req = 4'b1010;
    #1 chk_out("post_rst", 4'h2, 4'h3, 4'h0, 4'h0);
    @(negedge clk);
    req = 4'h0;
    #1 chk_out("post_rst_rsp", 4'h0, 4'h0, 4'h2, 4'hC);
    @(negedge clk);
    #1 chk_out("final_idle", 4'h0, 4'h0, 4'h0, 4'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
